// File: rtl/score_pkg.sv
// Shared types and constants for the score controller: FSM states, winner codes, digit limit.
package score_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StHold = 2'd2,
    StOver = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [2:0] MAX_DISPLAY_DIGIT = 3'd5;

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
    return (v >= lim) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running wrap counter 0..Div; tick is a registered one-cycle pulse on each wrap.
module tick_divider #(
  parameter int unsigned      Width = 18,
  parameter logic [Width-1:0] Div   = '1
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == Div);
    cnt_d  = tick_d ? '0 : cnt_q + Width'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/score_controller.sv
// Point counting, hold-off, winner detection and display scan tick for two players.
// Define BLINK_WINNER_EN to blank the loser's digit and blink the winner's digit in OVER.
module score_controller
  import score_pkg::*;
#(
  parameter logic [2:0]  WIN_SCORE = 3'd5,
  parameter logic [23:0] HOLD_CYC  = 24'd1000,
  parameter logic [17:0] TICK_DIV  = 18'd262143,
  parameter logic [25:0] BLINK_DIV = 26'd49999999
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [2:0] p1,
  output logic [2:0] p2,
  output logic       scan_tick,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       blank_p1,
  output logic       blank_p2
);

  // Never count past what the display can decode, whatever WIN_SCORE is set to.
  localparam logic [2:0] ScoreCap = (WIN_SCORE > MAX_DISPLAY_DIGIT) ? MAX_DISPLAY_DIGIT : WIN_SCORE;

  state_e      state_q, state_d;
  logic [2:0]  p1_q, p1_d, p2_q, p2_d;
  logic [23:0] hold_q, hold_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;

  tick_divider #(
    .Width(18),
    .Div  (TICK_DIV)
  ) u_scan_div (
    .clk (clk),
    .clr (clr),
    .tick(scan_tick)
  );

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPlay;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      StPlay: begin
        if (start) begin
          p1_d = '0;
          p2_d = '0;
        end else if (p1_point ^ p2_point) begin
          if (p1_point) p1_d = sat_inc(p1_q, ScoreCap);
          else          p2_d = sat_inc(p2_q, ScoreCap);
          hold_d  = HOLD_CYC;
          state_d = StHold;
        end
      end
      StHold: begin
        if (start) begin
          p1_d    = '0;
          p2_d    = '0;
          hold_d  = '0;
          state_d = StPlay;
        end else begin
          hold_d = hold_q - 24'd1;
          if (hold_q == 24'd1) begin
            if (p1_q == WIN_SCORE) begin
              state_d  = StOver;
              winner_d = WIN_P1;
            end else if (p2_q == WIN_SCORE) begin
              state_d  = StOver;
              winner_d = WIN_P2;
            end else begin
              state_d = StPlay;
            end
          end
        end
      end
      StOver: begin
        if (start) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
          state_d  = StPlay;
        end
      end
    endcase
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      p1_q        <= '0;
      p2_q        <= '0;
      hold_q      <= '0;
      winner_q    <= WIN_NONE;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      hold_q      <= hold_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
    end
  end

`ifdef BLINK_WINNER_EN
  logic blink_tick;
  logic phase_q, phase_d;

  // Held in reset outside OVER so every game-over starts with the winner shown.
  tick_divider #(
    .Width(26),
    .Div  (BLINK_DIV)
  ) u_blink_div (
    .clk (clk),
    .clr (clr | ~game_over_q),
    .tick(blink_tick)
  );

  always_comb phase_d = game_over_q ? (phase_q ^ blink_tick) : 1'b0;

  always_ff @(posedge clk) begin
    if (clr) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end

  always_comb begin
    blank_p1 = game_over_q && ((winner_q == WIN_P1) ? phase_q : 1'b1);
    blank_p2 = game_over_q && ((winner_q == WIN_P2) ? phase_q : 1'b1);
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blank_p1 = 1'b0;
  assign blank_p2 = 1'b0;
`endif

  assign p1        = p1_q;
  assign p2        = p2_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed and randomized checks of score_controller against a cycle-count reference model.
module tb_score_controller;

  localparam int WIN  = 3;
  localparam int HOLD = 4;
  localparam int TDIV = 9;
  localparam int BDIV = 7;

  logic       clk = 1'b0;
  logic       clr, start, p1_point, p2_point;
  logic [2:0] p1, p2;
  logic       scan_tick, game_over, blank_p1, blank_p2;
  logic [1:0] winner;

  always #5 clk = ~clk;

  score_controller #(
    .WIN_SCORE(3'(WIN)),
    .HOLD_CYC (24'(HOLD)),
    .TICK_DIV (18'(TDIV)),
    .BLINK_DIV(26'(BDIV))
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .p1_point (p1_point),
    .p2_point (p2_point),
    .p1       (p1),
    .p2       (p2),
    .scan_tick(scan_tick),
    .game_over(game_over),
    .winner   (winner),
    .blank_p1 (blank_p1),
    .blank_p2 (blank_p2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 play, 2 hold-off, 3 over. Hold-off expressed as an absolute
  // edge number at which the game resumes or ends.
  int m_mode, m_p1, m_p2, m_win, m_edge, m_resume, m_ticks, m_over_k;
  bit m_tick, m_valid = 0;

  always @(posedge clk) begin
    int prev;
    if (clr) begin
      m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_edge = 0; m_resume = 0;
      m_ticks = 0; m_tick = 0; m_over_k = 0; m_valid = 1;
    end else begin
      m_edge++;
      m_ticks++;
      m_tick = (m_ticks % (TDIV + 1)) == 0;
      prev = m_mode;
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          if (start) begin
            m_p1 = 0; m_p2 = 0;
          end else if (p1_point != p2_point) begin
            if (p1_point) m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1;
            else          m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1;
            m_resume = m_edge + HOLD;
            m_mode = 2;
          end
        end
        2: begin
          if (start) begin
            m_p1 = 0; m_p2 = 0; m_mode = 1;
          end else if (m_edge == m_resume) begin
            if (m_p1 == WIN)      begin m_mode = 3; m_win = 1; end
            else if (m_p2 == WIN) begin m_mode = 3; m_win = 2; end
            else m_mode = 1;
          end
        end
        default: if (start) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_mode = 1;
        end
      endcase
      m_over_k = (m_mode == 3 && prev == 3) ? m_over_k + 1 : 0;
    end
  end

  always @(negedge clk) begin
    int exp_b1, exp_b2, phase;
    if (m_valid) begin
      exp_b1 = 0;
      exp_b2 = 0;
`ifdef BLINK_WINNER_EN
      if (m_mode == 3) begin
        phase  = (m_over_k == 0) ? 0 : ((m_over_k - 1) / (BDIV + 1)) % 2;
        exp_b1 = (m_win == 1) ? phase : 1;
        exp_b2 = (m_win == 2) ? phase : 1;
      end
`else
      phase = 0;
`endif
      check("p1", 32'(p1), m_p1);
      check("p2", 32'(p2), m_p2);
      check("game_over", 32'(game_over), 32'(m_mode == 3));
      check("winner", 32'(winner), m_win);
      check("scan_tick", 32'(scan_tick), 32'(m_tick));
      check("blank_p1", 32'(blank_p1), exp_b1 + phase * 0);
      check("blank_p2", 32'(blank_p2), exp_b2);
    end
  end

  // Drive one cycle of inputs from a negedge and return at the next negedge.
  task automatic cyc(input bit s, input bit a, input bit b);
    start = s; p1_point = a; p2_point = b;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_p1", 32'(p1), 0);
    check("rst_winner", 32'(winner), 0);
    check("rst_game_over", 32'(game_over), 0);
    clr = 1'b0;
    repeat (25) cyc(0, 0, 0);

    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("point_latency_p1", 32'(p1), 1);
    repeat (HOLD) cyc(0, 0, 1);
    check("hold_ignores_p2", 32'(p2), 0);
    cyc(0, 0, 1);
    check("p2_after_hold", 32'(p2), 1);
    repeat (HOLD) cyc(0, 0, 0);

    cyc(0, 1, 1);
    check("contested_p1", 32'(p1), 1);
    check("contested_p2", 32'(p2), 1);
    cyc(0, 1, 0);
    check("still_play_p1", 32'(p1), 2);
    repeat (HOLD) cyc(0, 0, 0);

    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      if (i < 2) repeat (HOLD) cyc(0, 0, 0);
    end
    check("p2_reaches_win", 32'(p2), 3);
    repeat (HOLD - 1) cyc(0, 0, 0);
    check("not_over_yet", 32'(game_over), 0);
    cyc(0, 0, 0);
    check("over_after_hold", 32'(game_over), 1);
    check("winner_p2", 32'(winner), 2);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    check("frozen_p1", 32'(p1), 0);
    check("frozen_p2", 32'(p2), 3);

    cyc(1, 1, 0);
    check("restart_p2", 32'(p2), 0);
    check("restart_over", 32'(game_over), 0);
    check("restart_winner", 32'(winner), 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    clr = 1'b1;
    cyc(0, 0, 0);
    clr = 1'b0;
    check("clr_mid_hold_p1", 32'(p1), 0);
    cyc(0, 1, 0);
    check("idle_ignores_point", 32'(p1), 0);

    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      repeat (HOLD) cyc(0, 0, 0);
    end
    check("winner_p1", 32'(winner), 1);
    repeat (40) cyc(0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    clr = 1'b0;
    repeat (3) cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
